// File: rtl/i8035_bus_pkg.sv
// Shared widths, request kinds and FSM encodings for the 8035 external bus sequencer.
package i8035_bus_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int KIND_W = 2;
  localparam int NIB_W  = 4;
  localparam int CNT_W  = 3;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

  typedef enum logic [KIND_W-1:0] {
    KIND_FETCH = 2'd0,
    KIND_RD    = 2'd1,
    KIND_WR    = 2'd2,
    KIND_RSVD  = 2'd3
  } kind_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ALE  = 3'd1,
    ST_HOLD = 3'd2,
    ST_STRB = 3'd3,
    ST_RCV  = 3'd4
  } state_t;

  // The reserved kind code runs a program fetch.
  function automatic kind_t decode_kind(input logic [KIND_W-1:0] raw);
    case (raw)
      2'd1:    return KIND_RD;
      2'd2:    return KIND_WR;
      default: return KIND_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/i8035_ext_bus.sv
// Bus-cycle sequencer turning 8035 fetch/MOVX requests into ALE/PSENn/RDn/WRn cycles.
// Optional macro I8035_EXT_BUS_WAIT_EN adds I_WAITn to stretch the last strobe clock.
import i8035_bus_pkg::*;

module i8035_ext_bus #(
  parameter int ALE_CYC    = 1,
  parameter int STROBE_CYC = 3
) (
  input  logic              I_CLK1,
  input  logic              I_RST,
  input  logic              I_REQ,
  input  logic [KIND_W-1:0] I_KIND,
  input  logic [ADDR_W-1:0] I_ADDR,
  input  logic [DATA_W-1:0] I_WDATA,
  output logic              O_ACK,
  output logic [DATA_W-1:0] O_RDATA,
  output logic [DATA_W-1:0] O_DB,
  output logic              O_DB_OE,
  input  logic [DATA_W-1:0] I_DB,
  output logic              O_ALE,
  output logic              O_PSENn,
  output logic              O_RDn,
  output logic              O_WRn,
`ifdef I8035_EXT_BUS_WAIT_EN
  input  logic              I_WAITn,
`endif
  output logic [NIB_W-1:0]  O_P2_A
);

  state_t              state, state_next;
  kind_t               kind_q, kind_next;
  logic [ADDR_W-1:0]   addr_q, addr_next;
  logic [DATA_W-1:0]   wdata_q, wdata_next;
  cnt_t                cnt, cnt_next;
  logic                accept, strb_last, strb_done, waitn;

  logic                ale_d, oe_d, psen_d, rd_d, wr_d, ack_d;
  logic [DATA_W-1:0]   db_d;
  logic [NIB_W-1:0]    p2_d;

`ifdef I8035_EXT_BUS_WAIT_EN
  assign waitn = I_WAITn;
`else
  assign waitn = 1'b1;
`endif

  assign accept    = (state == ST_IDLE) && I_REQ;
  assign strb_last = (cnt == cnt_t'(STROBE_CYC - 1));
  assign strb_done = (state == ST_STRB) && strb_last && waitn;

  // Next-state and request-field selection.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_next = state;
    kind_next  = kind_q;
    addr_next  = addr_q;
    wdata_next = wdata_q;
    case (state)
      ST_IDLE: if (I_REQ) state_next = ST_ALE;
      ST_ALE:  if (cnt == cnt_t'(ALE_CYC - 1)) state_next = ST_HOLD;
      ST_HOLD: state_next = ST_STRB;
      ST_STRB: if (strb_last && waitn) state_next = ST_RCV;
      ST_RCV:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (accept) begin
      kind_next  = decode_kind(I_KIND);
      addr_next  = I_ADDR;
      wdata_next = I_WDATA;
    end
  end

  // Counter restarts on every state change and parks on the last strobe clock while waiting.
  always_comb begin
    cnt_next = cnt;
    if (state_next != state)
      cnt_next = '0;
    else if ((state == ST_STRB) && strb_last)
      cnt_next = cnt;
    else if (cnt != CNT_MAX)
      cnt_next = cnt + cnt_t'(1);
  end

  // Outputs are decoded from the next state so the registered pins line up with the state.
  always_comb begin
    ale_d  = 1'b0;
    oe_d   = 1'b0;
    psen_d = 1'b1;
    rd_d   = 1'b1;
    wr_d   = 1'b1;
    ack_d  = 1'b0;
    db_d   = O_DB;
    p2_d   = O_P2_A;
    case (state_next)
      ST_ALE: begin
        ale_d = 1'b1;
        oe_d  = 1'b1;
        db_d  = addr_next[DATA_W-1:0];
        if (kind_next == KIND_FETCH) p2_d = addr_next[ADDR_W-1:DATA_W];
      end
      ST_HOLD: begin
        oe_d = 1'b1;
        db_d = addr_next[DATA_W-1:0];
      end
      ST_STRB: begin
        case (kind_next)
          KIND_RD: rd_d = 1'b0;
          KIND_WR: begin
            wr_d = 1'b0;
            oe_d = 1'b1;
            db_d = wdata_next;
          end
          default: psen_d = 1'b0;
        endcase
      end
      ST_RCV:  ack_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge I_CLK1) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (I_RST) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      kind_q  <= KIND_FETCH;
      addr_q  <= '0;
      wdata_q <= '0;
      O_ACK   <= 1'b0;
      O_RDATA <= '0;
      O_DB    <= '0;
      O_DB_OE <= 1'b0;
      O_ALE   <= 1'b0;
      O_PSENn <= 1'b1;
      O_RDn   <= 1'b1;
      O_WRn   <= 1'b1;
      O_P2_A  <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      kind_q  <= kind_next;
      addr_q  <= addr_next;
      wdata_q <= wdata_next;
      O_ACK   <= ack_d;
      O_DB    <= db_d;
      O_DB_OE <= oe_d;
      O_ALE   <= ale_d;
      O_PSENn <= psen_d;
      O_RDn   <= rd_d;
      O_WRn   <= wr_d;
      O_P2_A  <= p2_d;
      if (strb_done && (kind_q != KIND_WR)) O_RDATA <= I_DB;
    end
  end

endmodule

// File: tb/tb_i8035_ext_bus.sv
// Directed bench for i8035_ext_bus; the wait-state test builds only with I8035_EXT_BUS_WAIT_EN.
module tb_i8035_ext_bus;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [1:0]  kind;
  logic [11:0] addr;
  logic [7:0]  wdata;
  logic        ack;
  logic [7:0]  rdata;
  logic [7:0]  db_out;
  logic        db_oe;
  logic [7:0]  db_in;
  logic        ale;
  logic        psen_n, rd_n, wr_n;
  logic [3:0]  p2_a;
`ifdef I8035_EXT_BUS_WAIT_EN
  logic        waitn = 1'b1;
`endif

  int checks = 0;
  int errors = 0;

  // Per-clock traces: bit k-1 holds clock k after the accepting edge (strobes stored active-high).
  logic [31:0] ale_tr, oe_tr, ack_tr, psen_tr, rd_tr, wr_tr;
  logic [7:0]  db_tr [1:32];

  always #5 clk = ~clk;

  i8035_ext_bus dut (
    .I_CLK1  (clk),
    .I_RST   (rst),
    .I_REQ   (req),
    .I_KIND  (kind),
    .I_ADDR  (addr),
    .I_WDATA (wdata),
    .O_ACK   (ack),
    .O_RDATA (rdata),
    .O_DB    (db_out),
    .O_DB_OE (db_oe),
    .I_DB    (db_in),
    .O_ALE   (ale),
    .O_PSENn (psen_n),
    .O_RDn   (rd_n),
    .O_WRn   (wr_n),
`ifdef I8035_EXT_BUS_WAIT_EN
    .I_WAITn (waitn),
`endif
    .O_P2_A  (p2_a)
  );

  task automatic clear_traces();
    ale_tr = '0; oe_tr = '0; ack_tr = '0; psen_tr = '0; rd_tr = '0; wr_tr = '0;
    for (int i = 1; i <= 32; i++) db_tr[i] = '0;
  endtask

  task automatic record(input int k);
    ale_tr[k-1]  = ale;
    oe_tr[k-1]   = db_oe;
    ack_tr[k-1]  = ack;
    psen_tr[k-1] = ~psen_n;
    rd_tr[k-1]   = ~rd_n;
    wr_tr[k-1]   = ~wr_n;
    db_tr[k]     = db_out;
  endtask

  // Present a request at a falling edge; the following rising edge accepts it.
  task automatic start_req(input logic [1:0] k, input logic [11:0] a, input logic [7:0] w);
    @(negedge clk);
    kind  = k;
    addr  = a;
    wdata = w;
    req   = 1'b1;
  endtask

  // Trace n clocks, releasing the request in the clock where the ACK shows.
  task automatic run_trace(input int n);
    clear_traces();
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      record(k);
      if (ack) req = 1'b0;
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; kind = 2'd0; addr = '0; wdata = '0; db_in = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ack, rdata, db_out, db_oe, ale, psen_n, rd_n, wr_n, p2_a} !== {1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0}) begin
      errors++;
      $display("FAIL reset_values: ack=%b rdata=%h db=%h oe=%b ale=%b psen=%b rd=%b wr=%b p2=%h", ack, rdata, db_out, db_oe, ale, psen_n, rd_n, wr_n, p2_a);
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    db_in = 8'hA5;
    start_req(2'd0, 12'h123, 8'h00);
    run_trace(8);
    chk32("t1_ale", ale_tr, 32'h01);
    chk32("t1_psen", psen_tr, 32'h1C);
    chk32("t1_rd_wr", rd_tr | wr_tr, 32'h0);
    chk32("t1_oe", oe_tr, 32'h03);
    chk32("t1_ack", ack_tr, 32'h20);
    chk32("t1_db_addr", {24'h0, db_tr[1]}, 32'h23);
    chk32("t1_db_hold", {24'h0, db_tr[2]}, 32'h23);
    chk32("t1_p2", {28'h0, p2_a}, 32'h1);
    chk32("t1_rdata", {24'h0, rdata}, 32'hA5);
  endtask

  task automatic test_movx_rd();
    db_in = 8'h15;
    start_req(2'd1, 12'h000, 8'h00);
    run_trace(8);
    chk32("t2_rd", rd_tr, 32'h1C);
    chk32("t2_psen_wr", psen_tr | wr_tr, 32'h0);
    chk32("t2_oe", oe_tr, 32'h03);
    chk32("t2_ack", ack_tr, 32'h20);
    chk32("t2_rdata", {24'h0, rdata}, 32'h15);
    chk32("t2_p2", {28'h0, p2_a}, 32'h1);
  endtask

  task automatic test_movx_wr();
    db_in = 8'h77;
    start_req(2'd2, 12'h080, 8'h3C);
    run_trace(8);
    chk32("t3_wr", wr_tr, 32'h1C);
    chk32("t3_psen_rd", psen_tr | rd_tr, 32'h0);
    chk32("t3_oe", oe_tr, 32'h1F);
    chk32("t3_db_addr", {24'h0, db_tr[1]}, 32'h80);
    chk32("t3_db_wdata", {8'h0, db_tr[3], db_tr[4], db_tr[5]}, 32'h3C3C3C);
    chk32("t3_ack", ack_tr, 32'h20);
    chk32("t3_rdata_kept", {24'h0, rdata}, 32'h15);
    chk32("t3_p2", {28'h0, p2_a}, 32'h1);
  endtask

  task automatic test_back_to_back();
    int n_ack;
    n_ack = 0;
    db_in = 8'hB0;
    start_req(2'd0, 12'h000, 8'h00);
    clear_traces();
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      record(k);
      if (k == 2) kind = 2'd2;
      if (k == 5) kind = 2'd0;
      if (ack) begin
        checks++;
        if (rdata !== 8'hB0 + 8'(n_ack)) begin
          errors++;
          $display("FAIL t4_rdata%0d: got %h expected %h", n_ack, rdata, 8'hB0 + 8'(n_ack));
        end
        n_ack++;
        if (n_ack < 3) begin
          addr  = 12'(n_ack);
          db_in = 8'hB0 + 8'(n_ack);
        end else begin
          req = 1'b0;
        end
      end
    end
    chk32("t4_ack", ack_tr, 32'h0008_1020);
    chk32("t4_psen", psen_tr, 32'h0007_0E1C);
    chk32("t4_rd_wr", rd_tr | wr_tr, 32'h0);
    chk32("t4_db", {16'h0, db_tr[8], db_tr[15]}, 32'h0102);
    chk32("t4_p2", {28'h0, p2_a}, 32'h0);
  endtask

  task automatic test_reset_abort();
    db_in = 8'hEE;
    start_req(2'd0, 12'h345, 8'h00);
    repeat (4) @(negedge clk);
    req = 1'b0;
    checks++;
    if (psen_n !== 1'b0) begin
      errors++;
      $display("FAIL t5_in_strobe: psen=%b expected 0", psen_n);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({psen_n, rd_n, wr_n, db_oe, ack, ale, rdata, p2_a} !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0}) begin
      errors++;
      $display("FAIL t5_abort: psen=%b rd=%b wr=%b oe=%b ack=%b ale=%b rdata=%h p2=%h", psen_n, rd_n, wr_n, db_oe, ack, ale, rdata, p2_a);
    end
    rst = 1'b0;
    clear_traces();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      record(k);
    end
    chk32("t5_no_ack_after", ack_tr | psen_tr, 32'h0);
    db_in = 8'h5A;
    start_req(2'd1, 12'h005, 8'h00);
    run_trace(8);
    chk32("t5_rd_after", rd_tr, 32'h1C);
    chk32("t5_ack_after", ack_tr, 32'h20);
    chk32("t5_rdata_after", {24'h0, rdata}, 32'h5A);
  endtask

`ifdef I8035_EXT_BUS_WAIT_EN
  task automatic test_wait();
    db_in = 8'h11;
    start_req(2'd0, 12'h123, 8'h00);
    clear_traces();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      record(k);
      if (k == 4) waitn = 1'b0;
      if (k == 9) begin
        waitn = 1'b1;
        db_in = 8'hC3;
      end
      if (ack) req = 1'b0;
    end
    chk32("t6_psen", psen_tr, 32'h1FC);
    chk32("t6_ack", ack_tr, 32'h200);
    chk32("t6_rdata", {24'h0, rdata}, 32'hC3);
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_movx_rd();
    test_movx_wr();
    test_back_to_back();
    test_reset_abort();
`ifdef I8035_EXT_BUS_WAIT_EN
    test_wait();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
